bitplane_serial_link: RTL
=========================

BITPLANE_SERIAL_LINK -- requirements
Module: bitplane_serial_link

Interface
REQ-001 Parameter W, default 8: bits per memory word; number of bit-plane packets per transfer.
REQ-002 Parameter N, default 18: words per transfer; data bits per packet.
REQ-003 Derived AW = clog2(W) (header bits) and MAW = clog2(N) (memory address width); W SHALL be at least 2 and N at least 2.
REQ-004 Ports, in this order:
  - clk  in  1  sole clock; all state updates on the rising edge.
  - rst  in  1  synchronous, active-low reset.
  - start  in  1  one-cycle request; sampled only in IDLE.
  - updown  in  1  direction, sampled with start: 0 = memory->serial (TX), 1 = serial->memory (RX).
  - RB_A  out  MAW  memory word address.
  - RB_RW  out  1  1 = read, 0 = write.
  - RB_D  out  W  memory write data.
  - RB_Q  in  W  memory read data, combinational from RB_A and valid in the same cycle.
  - sen_o / sen_oe / sen_i  out/out/in  1 each  serial frame enable (active-low frame); split tri-state.
  - sd_o / sd_oe / sd_i  out/out/in  1 each  serial data; split tri-state.
  - busy  out  1  high in every state except IDLE.
  - done  out  1  one-cycle pulse at transfer completion.
  - err  out  1  sticky RX framing error.

Function
REQ-005 The states SHALL be IDLE, READ, TX, TX_GAP, RX, WRITE and DONE.
REQ-006 IDLE SHALL go to READ on start=1 with updown=0, to RX on start=1 with updown=1, and otherwise stay in IDLE.
REQ-007 start in any state other than IDLE SHALL be ignored.
REQ-008 READ SHALL last N cycles with RB_RW=1 and RB_A=0..N-1, capturing buf[RB_A] <= RB_Q each cycle, then go to TX with packet k=0 and bit counter j=0.
REQ-009 In TX, packet k SHALL occupy AW+N cycles (j=0..AW+N-1) with sen_o=0 and sd_oe=1.
REQ-010 TX sd_o for j<AW SHALL be bit AW-1-j of k (header MSB first).
REQ-011 TX sd_o for j>=AW SHALL be bit W-1-k of buf[N-1-(j-AW)] (highest word first; packet k carries bit plane W-1-k).
REQ-012 After j=AW+N-1, TX SHALL go to TX_GAP for exactly one cycle with sen_o=1 and sd_oe=0.
REQ-013 From TX_GAP the block SHALL go to DONE if k=W-1, else return to TX with k+1 and j=0.
REQ-014 sen_oe SHALL be 1 in READ, TX and TX_GAP, and 0 otherwise; sen_o SHALL be 0 only in TX.
REQ-015 In RX, sen_oe and sd_oe SHALL both be 0.
REQ-016 In RX, each cycle with sen_i=0 SHALL shift sd_i into a receive register and increment the bit count, saturating at AW+N+1.
REQ-017 An RX packet SHALL end on the first cycle with sen_i=1 and bit count > 0; the bit count then SHALL clear.
REQ-018 An ended packet SHALL be accepted only if bit count = AW+N and header a < W.
REQ-019 An accepted packet SHALL write its i-th data bit (i=0..N-1, arrival order) into bit W-1-a of rbuf[N-1-i] and set mask[a].
REQ-020 A duplicate header SHALL overwrite the earlier plane without other effect.
REQ-021 A rejected packet SHALL set err and be discarded; RX SHALL continue.
REQ-022 When mask is all ones, RX SHALL go to WRITE on the next cycle.
REQ-023 WRITE SHALL last N cycles with RB_RW=0, RB_A=0..N-1 and RB_D=rbuf[RB_A], then go to DONE.
REQ-024 DONE SHALL assert done for one cycle, clear mask, return to IDLE, and leave err unchanged.
REQ-025 Outside READ and WRITE, RB_RW SHALL be 1 and RB_A SHALL hold its last value.
REQ-026 err SHALL clear only on reset or on start accepted in IDLE.

Reset
REQ-027 rst=0 at a rising edge SHALL force: state IDLE, RB_A=0, RB_RW=1, RB_D=0, busy=0, done=0, err=0, sen_oe=0, sd_oe=0, sen_o=1, sd_o=0, j=k=0, mask=0, all buffers 0.
REQ-028 Reset in any state SHALL abort the transfer, with no memory write on or after that edge.

Verification
REQ-029 TX, defaults, RB words m[i]=i: after 18 READ cycles, packet k=0 SHALL be header 000 then bit 7 of words 17..0 (all 0); 8 packets of 21 low-sen cycles each plus 1-cycle gaps; done pulses once, 8*22+18+1 cycles after start.
REQ-030 TX, m[i]=8'hFF except m[0]=8'h00: every packet SHALL end with data bit 0, and headers SHALL be 000..111 in order.
REQ-031 RX loopback of the REQ-029 stream, packets sent in order 7..0: memory SHALL be written with rbuf[i]=i, RB_RW=0 for exactly 18 cycles, and err=0.
REQ-032 RX with one 20-bit frame, then 8 valid frames: err=1, the write completes correctly, and done pulses.
REQ-033 RX with header 3 sent twice (second frame all-ones), then the others: WRITE SHALL not start before header 7 arrives, and bit 4 of every word SHALL be 1.
REQ-034 rst=0 mid-TX at j=5 of packet 2: next cycle sen_oe=0, sd_oe=0, busy=0; a new start SHALL restart at READ with RB_A=0.

Source files
------------

// File: rtl/bitplane_serial_link.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitplane_serial_link: N-word memory block <-> W serial bit-plane packets.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bitplane_serial_link #(
  parameter  int W   = 8,
  parameter  int N   = 18,
  localparam int AW  = $clog2(W),
  localparam int MAW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           updown,
  output logic [MAW-1:0] RB_A,
  output logic           RB_RW,
  output logic [W-1:0]   RB_D,
  input  logic [W-1:0]   RB_Q,
  output logic           sen_o,
  output logic           sen_oe,
  input  logic           sen_i,
  output logic           sd_o,
  output logic           sd_oe,
  input  logic           sd_i,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_TX, S_TX_GAP, S_RX, S_WRITE, S_DONE
  } state_t;

  localparam int              FL      = AW + N;
  localparam int              JW      = $clog2(FL + 2);
  localparam logic [JW-1:0]   J_LAST  = JW'(FL - 1);
  localparam logic [JW-1:0]   BC_FULL = JW'(FL);
  localparam logic [JW-1:0]   BC_SAT  = JW'(FL + 1);
  localparam logic [JW-1:0]   J_HDR   = JW'(AW);
  localparam logic [MAW-1:0]  A_LAST  = MAW'(N - 1);
  localparam logic [AW-1:0]   K_LAST  = AW'(W - 1);
  localparam logic [AW:0]     W_LIM   = (AW + 1)'(W);

  state_t                  state_q, state_d;
  logic [MAW-1:0]          addr_q, addr_d;
  logic [AW-1:0]           k_q, k_d;
  logic [JW-1:0]           j_q, j_d;
  logic [JW-1:0]           bc_q, bc_d;
  logic [FL-1:0]           sr_q, sr_d;
  logic [N-1:0][W-1:0]     buf_q, buf_d;
  logic [N-1:0][W-1:0]     rbuf_q, rbuf_d;
  logic [W-1:0]            mask_q, mask_d;
  logic                    err_q, err_d;

  logic [AW-1:0]           hidx;
  logic [MAW-1:0]          widx;
  logic [AW-1:0]           plane_tx;
  logic [AW-1:0]           hdr;
  logic [AW-1:0]           plane_rx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      k_q     <= '0;
      j_q     <= '0;
      bc_q    <= '0;
      sr_q    <= '0;
      buf_q   <= '0;
      rbuf_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
      j_q     <= j_d;
      bc_q    <= bc_d;
      sr_q    <= sr_d;
      buf_q   <= buf_d;
      rbuf_q  <= rbuf_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    k_d      = k_q;
    j_d      = j_q;
    bc_d     = bc_q;
    sr_d     = sr_q;
    buf_d    = buf_q;
    rbuf_d   = rbuf_q;
    mask_d   = mask_q;
    err_d    = err_q;
    // Header is sent MSB first; payload walks words from N-1 down to 0.
    hidx     = AW'(AW - 1) - AW'(j_q);
    widx     = MAW'(FL - 1) - MAW'(j_q);
    plane_tx = K_LAST - k_q;
    hdr      = sr_q[FL-1 -: AW];
    plane_rx = K_LAST - hdr;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          bc_d  = '0;
          if (updown) begin
            state_d = S_RX;
          end else begin
            state_d = S_READ;
            addr_d  = '0;
          end
        end
      end
      S_READ: begin
        buf_d[addr_q] = RB_Q;
        if (addr_q == A_LAST) begin
          state_d = S_TX;
          k_d     = '0;
          j_d     = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_TX: begin
        if (j_q == J_LAST) begin
          state_d = S_TX_GAP;
          j_d     = '0;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_TX_GAP: begin
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          k_d     = '0;
        end else begin
          state_d = S_TX;
          k_d     = k_q + 1'b1;
        end
      end
      S_RX: begin
        if (&mask_q) begin
          state_d = S_WRITE;
          addr_d  = '0;
        end
        if (!sen_i) begin
          sr_d = {sr_q[FL-2:0], sd_i};
          if (bc_q != BC_SAT) begin
            bc_d = bc_q + 1'b1;
          end
        end else if (bc_q != '0) begin
          bc_d = '0;
          // Data bits sit in sr_q[N-1:0] with the first-arrived bit at N-1,
          // which is exactly the word index it belongs to.
          if (bc_q == BC_FULL && {1'b0, hdr} < W_LIM) begin
            for (int m = 0; m < N; m++) begin
              rbuf_d[m][plane_rx] = sr_q[m];
            end
            mask_d[hdr] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (addr_q == A_LAST) begin
          state_d = S_DONE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DONE: begin
        mask_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A reset edge that lands during WRITE must not commit one more word.
  assign RB_RW  = !((state_q == S_WRITE) && rst);
  assign RB_A   = addr_q;
  assign RB_D   = (state_q == S_WRITE) ? rbuf_q[addr_q] : '0;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign sen_oe = (state_q == S_READ) || (state_q == S_TX) || (state_q == S_TX_GAP);
  assign sen_o  = (state_q != S_TX);
  assign sd_oe  = (state_q == S_TX);
  assign sd_o   = (state_q != S_TX) ? 1'b0 :
                  (j_q < J_HDR)     ? k_q[hidx] : buf_q[widx][plane_tx];

endmodule
`default_nettype wire
